// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_pkg
//  Brief    : Clause-22 MDIO frame constants, field widths and responder states.
//  Revision : 1.0 - initial release
// ============================================================================
package mdio_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int PRE_W  = 6;

    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] TA_WR   = 2'b10;

    localparam logic [PRE_W-1:0] PRE_LEN = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_DATA  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mdio_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_edge_sync
//  Brief    : 2-flop synchronizers for MDC/MDIO plus MDC rise/fall strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module mdio_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdio_in,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_sync
);

    // Bit 1 is the synchronized MDC, bit 2 its one-cycle-old copy for edge detection.
    logic [2:0] r_mdc_sync;
    logic [1:0] r_mdio_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdc_sync  <= '0;
            r_mdio_sync <= '0;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[1:0], mdc};
            r_mdio_sync <= {r_mdio_sync[0], mdio_in};
        end
    end

    assign mdc_rise  =  r_mdc_sync[1] & ~r_mdc_sync[2];
    assign mdc_fall  = ~r_mdc_sync[1] &  r_mdc_sync[2];
    assign mdio_sync =  r_mdio_sync[1];

endmodule
`default_nettype wire

// File: rtl/mdio_slave.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_slave
//  Brief    : Clause-22 MDIO responder with a 32 x 16-bit register file.
//  Revision : 1.0 - initial release
// ============================================================================
module mdio_slave
    import mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR   = 5'h04,
    parameter logic [DATA_W-1:0] PHY_ID1    = 16'h001C,
    parameter logic [DATA_W-1:0] PHY_ID2    = 16'hC915,
    parameter logic [DATA_W-1:0] STATUS_VAL = 16'h796D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mdc,
    input  logic              mdio_in,
    output logic              mdio_out,
    output logic              mdio_oe,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              soft_rst,
    output logic              frame_err
);

    logic w_rise;
    logic w_fall;
    logic w_bit;

    mdio_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc      (mdc),
        .mdio_in  (mdio_in),
        .mdc_rise (w_rise),
        .mdc_fall (w_fall),
        .mdio_sync(w_bit)
    );

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [PRE_W-1:0]  r_pre;
    logic [3:0]        r_acc;
    logic              r_is_read;
    logic [ADDR_W-1:0] r_regad;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_regs [0:31];

    logic [ADDR_W-1:0] w_acc_next;
    logic [DATA_W-1:0] w_data_next;
    logic [DATA_W-1:0] w_rd_val;

    assign w_acc_next  = {r_acc, w_bit};
    assign w_data_next = {r_shift[DATA_W-2:0], w_bit};

    always_comb begin
        w_rd_val = r_regs[w_acc_next];
        case (w_acc_next)
            5'd1:    w_rd_val = STATUS_VAL;
            5'd2:    w_rd_val = PHY_ID1;
            5'd3:    w_rd_val = PHY_ID2;
            default: w_rd_val = r_regs[w_acc_next];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pre     <= '0;
            r_acc     <= '0;
            r_is_read <= 1'b0;
            r_regad   <= '0;
            r_shift   <= '0;
            mdio_out  <= 1'b0;
            mdio_oe   <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            soft_rst  <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            wr_pulse  <= 1'b0;
            soft_rst  <= 1'b0;
            frame_err <= 1'b0;

            if (w_rise) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_bit) begin
                            if (r_pre < PRE_LEN) r_pre <= r_pre + 1'b1;
                        end else begin
                            if (r_pre >= PRE_LEN) r_state <= S_ST;
                            r_pre <= '0;
                        end
                    end
                    S_ST: begin
                        r_cnt <= '0;
                        if ({1'b0, w_bit} == ST_CODE) begin
                            r_state <= S_OP;
                        end else begin
                            r_state   <= S_IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                    S_OP: begin
                        r_acc <= w_acc_next[3:0];
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == 4'd1) begin
                            r_cnt <= '0;
                            if ({r_acc[0], w_bit} == OP_RD) begin
                                r_is_read <= 1'b1;
                                r_state   <= S_PHYAD;
                            end else if ({r_acc[0], w_bit} == OP_WR) begin
                                r_is_read <= 1'b0;
                                r_state   <= S_PHYAD;
                            end else begin
                                r_state   <= S_IDLE;
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    S_PHYAD: begin
                        r_acc <= w_acc_next[3:0];
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == 4'(ADDR_W - 1)) begin
                            r_cnt   <= '0;
                            // Frames for other PHYs are dropped without any error indication.
                            r_state <= (w_acc_next == PHY_ADDR) ? S_REGAD : S_IDLE;
                        end
                    end
                    S_REGAD: begin
                        r_acc <= w_acc_next[3:0];
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == 4'(ADDR_W - 1)) begin
                            r_cnt   <= '0;
                            r_regad <= w_acc_next;
                            r_state <= S_TA;
                            if (r_is_read) r_shift <= w_rd_val;
                        end
                    end
                    S_TA: begin
                        r_acc <= w_acc_next[3:0];
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == 4'd1) begin
                            r_cnt <= '0;
                            if (!r_is_read && ({r_acc[0], w_bit} != TA_WR)) begin
                                r_state   <= S_IDLE;
                                frame_err <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (!r_is_read) r_shift <= w_data_next;
                        if (r_cnt == 4'(DATA_W - 1)) begin
                            r_cnt   <= '0;
                            r_pre   <= '0;
                            r_state <= S_IDLE;
                            if (!r_is_read) begin
                                wr_pulse <= 1'b1;
                                wr_addr  <= r_regad;
                                wr_data  <= w_data_next;
                                // Bit 15 of register 0 is a self-clearing reset request.
                                if (r_regad == 5'd0) begin
                                    r_regs[0] <= {1'b0, w_data_next[DATA_W-2:0]};
                                    soft_rst  <= w_data_next[DATA_W-1];
                                end else if (r_regad > 5'd3) begin
                                    r_regs[r_regad] <= w_data_next;
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            if (w_fall) begin
                if (r_is_read && r_state == S_TA && r_cnt == 4'd1) begin
                    mdio_oe  <= 1'b1;
                    mdio_out <= 1'b0;
                end else if (r_is_read && r_state == S_DATA) begin
                    mdio_oe  <= 1'b1;
                    mdio_out <= r_shift[DATA_W-1];
                    r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
                end else begin
                    mdio_oe  <= 1'b0;
                    mdio_out <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdio_slave
//  Brief    : Directed self-checking bench acting as MDIO master for mdio_slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mdc = 1'b0;
    logic        m_drive = 1'b1;
    logic        m_val = 1'b1;
    wire         mdio_in;
    logic        mdio_out;
    logic        mdio_oe;
    logic        wr_pulse;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        soft_rst;
    logic        frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Pad model: master drive wins, else responder drive, else pull-up.
    assign mdio_in = m_drive ? m_val : (mdio_oe ? mdio_out : 1'b1);

    mdio_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc      (mdc),
        .mdio_in  (mdio_in),
        .mdio_out (mdio_out),
        .mdio_oe  (mdio_oe),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .soft_rst (soft_rst),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int wr_n = 0, srst_hi = 0, ferr_hi = 0, both_n = 0;
    always @(negedge clk) begin
        if (wr_pulse) wr_n++;
        if (soft_rst) srst_hi++;
        if (frame_err) ferr_hi++;
        if (wr_pulse && frame_err) both_n++;
    end

    task automatic send_bit(input logic b);
        m_drive = 1'b1;
        m_val   = b;
        #80 mdc = 1'b1;
        #80 mdc = 1'b0;
    endtask

    task automatic recv_bit(output logic b, output logic oe);
        m_drive = 1'b0;
        #80;
        b  = mdio_in;
        oe = mdio_oe;
        mdc = 1'b1;
        #80 mdc = 1'b0;
    endtask

    task automatic send_hdr(input int npre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra);
        repeat (npre) send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1);
        send_bit(op[1]); send_bit(op[0]);
        for (int i = 4; i >= 0; i--) send_bit(phy[i]);
        for (int i = 4; i >= 0; i--) send_bit(ra[i]);
    endtask

    task automatic write_frame(input int npre, input logic [4:0] phy, input logic [4:0] ra,
                               input logic [15:0] d);
        send_hdr(npre, 2'b01, phy, ra);
        send_bit(1'b1); send_bit(1'b0);
        for (int i = 15; i >= 0; i--) send_bit(d[i]);
        m_val = 1'b1;
    endtask

    task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra,
                              output logic [15:0] d, output int oe_n, output logic ta2);
        logic b, oe;
        oe_n = 0;
        d    = '0;
        send_hdr(32, 2'b10, phy, ra);
        recv_bit(b, oe); oe_n += int'(oe);
        recv_bit(b, oe); oe_n += int'(oe); ta2 = b;
        for (int i = 0; i < 16; i++) begin
            recv_bit(b, oe); oe_n += int'(oe);
            d = {d[14:0], b};
        end
        repeat (2) begin recv_bit(b, oe); oe_n += int'(oe); end
        m_drive = 1'b1;
        m_val   = 1'b1;
    endtask

    task automatic test_reset();
        #40;
        n_tests++; if (mdio_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", mdio_oe); end
        n_tests++; if (mdio_out !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b expected 0", mdio_out); end
        rst_n = 1'b1;
        #40;
        n_tests++; if ({wr_pulse, soft_rst, frame_err} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000", {wr_pulse, soft_rst, frame_err}); end
        n_tests++; if ({wr_addr, wr_data} !== 21'h0) begin n_fail++; $display("FAIL reset_wr_bus: got %h expected 0", {wr_addr, wr_data}); end
    endtask

    task automatic test_write_read();
        logic [15:0] d; int oe_n; logic ta2; int w0;
        w0 = wr_n;
        write_frame(32, 5'h04, 5'h10, 16'hA5A5);
        n_tests++; if (wr_n - w0 !== 1) begin n_fail++; $display("FAIL wr_pulse_count: got %0d expected 1", wr_n - w0); end
        n_tests++; if (wr_addr !== 5'h10) begin n_fail++; $display("FAIL wr_addr: got %h expected 10", wr_addr); end
        n_tests++; if (wr_data !== 16'hA5A5) begin n_fail++; $display("FAIL wr_data: got %h expected a5a5", wr_data); end
        read_frame(5'h04, 5'h10, d, oe_n, ta2);
        n_tests++; if (d !== 16'hA5A5) begin n_fail++; $display("FAIL read_r10: got %h expected a5a5", d); end
        n_tests++; if (ta2 !== 1'b0) begin n_fail++; $display("FAIL ta2_drive: got %b expected 0", ta2); end
        n_tests++; if (oe_n !== 17) begin n_fail++; $display("FAIL oe_periods: got %0d expected 17", oe_n); end
    endtask

    task automatic test_readonly();
        logic [15:0] d; int oe_n; logic ta2; int w0;
        read_frame(5'h04, 5'h01, d, oe_n, ta2);
        n_tests++; if (d !== 16'h796D) begin n_fail++; $display("FAIL read_r1: got %h expected 796d", d); end
        read_frame(5'h04, 5'h02, d, oe_n, ta2);
        n_tests++; if (d !== 16'h001C) begin n_fail++; $display("FAIL read_r2: got %h expected 001c", d); end
        read_frame(5'h04, 5'h03, d, oe_n, ta2);
        n_tests++; if (d !== 16'hC915) begin n_fail++; $display("FAIL read_r3: got %h expected c915", d); end
        w0 = wr_n;
        write_frame(32, 5'h04, 5'h02, 16'hFFFF);
        n_tests++; if (wr_n - w0 !== 1) begin n_fail++; $display("FAIL ro_wr_pulse: got %0d expected 1", wr_n - w0); end
        read_frame(5'h04, 5'h02, d, oe_n, ta2);
        n_tests++; if (d !== 16'h001C) begin n_fail++; $display("FAIL ro_r2_after_wr: got %h expected 001c", d); end
    endtask

    task automatic test_wrong_phy();
        logic [15:0] d; int oe_n; logic ta2; int w0;
        w0 = wr_n;
        write_frame(32, 5'h05, 5'h11, 16'h1234);
        n_tests++; if (wr_n - w0 !== 0) begin n_fail++; $display("FAIL phy5_wr_pulse: got %0d expected 0", wr_n - w0); end
        read_frame(5'h05, 5'h10, d, oe_n, ta2);
        n_tests++; if (oe_n !== 0) begin n_fail++; $display("FAIL phy5_oe: got %0d expected 0", oe_n); end
        write_frame(32, 5'h04, 5'h11, 16'h1234);
        read_frame(5'h04, 5'h11, d, oe_n, ta2);
        n_tests++; if (d !== 16'h1234) begin n_fail++; $display("FAIL phy4_after_phy5: got %h expected 1234", d); end
    endtask

    task automatic test_preamble();
        logic [15:0] d; int oe_n; logic ta2; int w0, f0;
        w0 = wr_n;
        send_bit(1'b0);
        write_frame(31, 5'h04, 5'h12, 16'h5555);
        n_tests++; if (wr_n - w0 !== 0) begin n_fail++; $display("FAIL pre31_wr_pulse: got %0d expected 0", wr_n - w0); end
        read_frame(5'h04, 5'h12, d, oe_n, ta2);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL pre31_r12: got %h expected 0000", d); end
        w0 = wr_n;
        send_bit(1'b0);
        write_frame(32, 5'h04, 5'h12, 16'h5555);
        n_tests++; if (wr_n - w0 !== 1) begin n_fail++; $display("FAIL pre32_wr_pulse: got %0d expected 1", wr_n - w0); end
        read_frame(5'h04, 5'h12, d, oe_n, ta2);
        n_tests++; if (d !== 16'h5555) begin n_fail++; $display("FAIL pre32_r12: got %h expected 5555", d); end
        f0 = ferr_hi;
        w0 = wr_n;
        repeat (32) send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        repeat (8) send_bit(1'b1);
        n_tests++; if (ferr_hi - f0 !== 1) begin n_fail++; $display("FAIL op11_frame_err: got %0d expected 1", ferr_hi - f0); end
        n_tests++; if (wr_n - w0 !== 0) begin n_fail++; $display("FAIL op11_wr_pulse: got %0d expected 0", wr_n - w0); end
    endtask

    task automatic test_soft_rst();
        logic [15:0] d; int oe_n; logic ta2; int s0;
        s0 = srst_hi;
        write_frame(32, 5'h04, 5'h00, 16'h8000);
        n_tests++; if (srst_hi - s0 !== 1) begin n_fail++; $display("FAIL soft_rst_width: got %0d expected 1", srst_hi - s0); end
        read_frame(5'h04, 5'h00, d, oe_n, ta2);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL r0_readback: got %h expected 0000", d); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] d; int oe_n; logic ta2; logic b, oe;
        send_hdr(32, 2'b10, 5'h04, 5'h10);
        recv_bit(b, oe); recv_bit(b, oe);
        for (int i = 0; i < 7; i++) recv_bit(b, oe);
        #40;
        n_tests++; if (mdio_oe !== 1'b1) begin n_fail++; $display("FAIL bit8_oe_before: got %b expected 1", mdio_oe); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (mdio_oe !== 1'b0) begin n_fail++; $display("FAIL async_rst_oe: got %b expected 0", mdio_oe); end
        #49;
        m_drive = 1'b1;
        m_val   = 1'b1;
        rst_n   = 1'b1;
        #40;
        read_frame(5'h04, 5'h10, d, oe_n, ta2);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL r10_after_rst: got %h expected 0000", d); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_readonly();
        test_wrong_phy();
        test_preamble();
        test_soft_rst();
        test_reset_mid_read();
        n_tests++; if (both_n !== 0) begin n_fail++; $display("FAIL err_wr_overlap: got %0d expected 0", both_n); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
